// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment driver: double-buffered digit data, per-digit blanking,
// leading-zero suppression, an all-dark gap at the start of each slot, and selectable output polarity.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 100000,
    parameter int GAP_CYCLES     = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done,
    output logic                    load_pending
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {PH_GAP, PH_DRIVE} phase_t;

    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic [IW-1:0]           index;
    logic [IW-1:0]           index_next;
    logic                    slot_end;
    logic                    boundary;
    phase_t                  phase;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_dark;
    logic                    all_zero;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b0001101;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            index <= '0;
        end else begin
            count <= count_next;
            index <= index_next;
        end
    end

    always_comb begin
        slot_end   = (count == COUNT_LAST);
        boundary   = slot_end && (index == INDEX_LAST);
        count_next = slot_end ? '0 : count + 1'b1;
        index_next = index;
        if (slot_end) begin
            index_next = (index == INDEX_LAST) ? '0 : index + 1'b1;
        end
    end

    // A zero-length gap would make the compare constant, so it is elaborated away.
    generate
        if (GAP_CYCLES == 0) begin : g_no_gap
            assign phase = PH_DRIVE;
        end else begin : g_gap
            assign phase = (count < CW'(GAP_CYCLES)) ? PH_GAP : PH_DRIVE;
        end
    endgenerate

    // Transfer happens with the old pending contents, so a load on the boundary edge stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val     <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            act_val      <= '0;
            act_dp       <= '0;
            act_blank    <= '0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_val     <= value_in;
                pend_dp      <= dp_in;
                pend_blank   <= blank_in;
                load_pending <= 1'b1;
            end else if (boundary && load_pending) begin
                load_pending <= 1'b0;
            end
            if (boundary && load_pending) begin
                act_val   <= pend_val;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
        end
    end

    always_comb begin
        all_zero   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (act_val[4*i +: 4] == 4'h0);
            upper_zero[i] = all_zero;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_sel   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur_nib   = act_val[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_dark  = act_blank[i] || (lz_en && (i > 0) && upper_zero[i]);
                an_sel[i] = 1'b1;
            end
        end
        an_next  = '0;
        seg_next = '0;
        dp_next  = 1'b0;
        if (phase == PH_DRIVE) begin
            an_next = an_sel;
            if (!cur_dark) begin
                seg_next = decode_hex(cur_nib);
                dp_next  = cur_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_out     <= {NUM_DIGITS{AN_INV}};
            seg_out    <= {7{SEG_INV}};
            dp_out     <= SEG_INV;
            frame_done <= 1'b0;
        end else begin
            an_out     <= an_next ^ {NUM_DIGITS{AN_INV}};
            seg_out    <= seg_next ^ {7{SEG_INV}};
            dp_out     <= dp_next ^ SEG_INV;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: an active-low and an active-high instance share stimulus
// and are both compared every cycle against a slot/frame arithmetic model of the display.
module tb_seven_segment_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = N * DIV;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;

    logic [6:0]  seg_al, seg_ah;
    logic        dp_al, dp_ah;
    logic [3:0]  an_al, an_ah;
    logic        fd_al, fd_ah;
    logic        lp_al, lp_ah;

    int vectors = 0;
    int errors  = 0;

    int          pos;
    int          m_off;
    int          m_digit;
    logic [3:0]  m_nib;
    logic        m_dark;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank;
    logic        m_lp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .GAP_CYCLES(GAP), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lz_en(lz_en), .seg_out(seg_al), .dp_out(dp_al), .an_out(an_al),
        .frame_done(fd_al), .load_pending(lp_al)
    );

    seven_segment_scan_driver #(
        .NUM_DIGITS(N), .CLK_DIV(DIV), .GAP_CYCLES(GAP), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_ah (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lz_en(lz_en), .seg_out(seg_ah), .dp_out(dp_ah), .an_out(an_ah),
        .frame_done(fd_ah), .load_pending(lp_ah)
    );

    // Model: pos counts edges since reset; slot, digit and frame position follow by division.
    always @(posedge clk) begin
        if (reset) begin
            pos = 0;
            m_act_val = '0; m_act_dp = '0; m_act_blank = '0;
            m_pend_val = '0; m_pend_dp = '0; m_pend_blank = '0;
            m_lp = 1'b0;
            e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            m_off   = pos % DIV;
            m_digit = (pos / DIV) % N;
            m_nib   = 4'((m_act_val >> (4 * m_digit)) & 16'hF);
            m_dark  = m_act_blank[m_digit] ||
                      (lz_en && (m_digit > 0) && ((m_act_val >> (4 * m_digit)) == 16'h0));
            if (m_off < GAP) begin
                e_an = '0; e_seg = '0; e_dp = 1'b0;
            end else begin
                e_an  = 4'(1 << m_digit);
                e_seg = m_dark ? 7'b0 : SEG_TABLE[m_nib];
                e_dp  = !m_dark && m_act_dp[m_digit];
            end
            e_fd = ((pos % FRAME) == FRAME - 1);
            if (e_fd && m_lp) begin
                m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                m_lp = 1'b0;
            end
            if (load) begin
                m_pend_val = value_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
                m_lp = 1'b1;
            end
            pos++;
        end
    end

    function automatic logic [27:0] obs_vec();
        return {an_al, seg_al, dp_al, fd_al, lp_al, an_ah, seg_ah, dp_ah, fd_ah, lp_ah};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {~e_an, ~e_seg, ~e_dp, e_fd, m_lp, e_an, e_seg, e_dp, e_fd, m_lp};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            vectors++;
            if ({an_al, seg_al, dp_al, fd_al, lp_al} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_outputs got %b want %b",
                         {an_al, seg_al, dp_al, fd_al, lp_al}, {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL post_reset got %h want %h", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if ({an_al, seg_al} !== {4'b1110, 7'b0000001}) begin
            errors++;
            $display("[TB] FAIL first_drive got %b want %b", {an_al, seg_al}, {4'b1110, 7'b0000001});
        end
    endtask

    task automatic test_load_transfer();
        int fd_count = 0;
        value_in = 16'h12AF; dp_in = 4'b0100; blank_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        vectors++;
        if (lp_al !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_pending_set got %b want 1", lp_al);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (fd_al === 1'b1) fd_count++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL load_transfer got %h want %h", obs_vec(), exp_vec());
            end
            if (e_an == 4'b0001 && m_act_val == 16'h12AF) begin
                vectors++;
                if ({an_al, seg_al, dp_al} !== {4'b1110, 7'b0111000, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL digit0_F got %b want %b",
                             {an_al, seg_al, dp_al}, {4'b1110, 7'b0111000, 1'b1});
                end
            end
        end
        vectors++;
        if (fd_count != 2) begin
            errors++;
            $display("[TB] FAIL frame_done_count got %0d want 2", fd_count);
        end
    endtask

    task automatic test_lz();
        int guard = 0;
        value_in = 16'h0050; dp_in = 4'b0000; blank_in = 4'b0000; lz_en = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_lp && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        vectors++;
        if (guard >= 2 * FRAME) begin
            errors++;
            $display("[TB] FAIL lz_transfer_timeout got %0d want <%0d", guard, 2 * FRAME);
        end
        for (int pass = 0; pass < 2; pass++) begin
            lz_en = (pass == 0);
            for (int i = 0; i < FRAME; i++) begin
                tick();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL lz_pass%0d got %h want %h", pass, obs_vec(), exp_vec());
                end
                if (pass == 0 && e_an == 4'b1000) begin
                    vectors++;
                    if ({an_al, seg_al} !== {4'b0111, 7'b1111111}) begin
                        errors++;
                        $display("[TB] FAIL lz_digit3_dark got %b want %b",
                                 {an_al, seg_al}, {4'b0111, 7'b1111111});
                    end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        while ((pos % FRAME) != FRAME - 3 && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        value_in = 16'h1111; dp_in = '0; blank_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        value_in = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        vectors++;
        if (lp_al !== 1'b1 || fd_al !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_load got lp=%b fd=%b want lp=1 fd=1", lp_al, fd_al);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL back_to_back got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midslot();
        int guard = 0;
        while ((pos % FRAME) != 2 * DIV + 4 && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        value_in = 16'h9876; dp_in = 4'b1111; blank_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({an_al, seg_al, dp_al, fd_al, lp_al} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midslot_reset got %b want %b",
                     {an_al, seg_al, dp_al, fd_al, lp_al}, {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0});
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL after_reset got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20 * FRAME; i++) begin
            load = ($urandom_range(0, 15) == 0);
            value_in = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value_in[15:8] = 8'h00;
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random got %h want %h", obs_vec(), exp_vec());
            end
        end
        load = 1'b0;
    endtask

    initial begin
        $display("[TB] starting seven_segment_scan_driver bench");
        test_reset();
        test_load_transfer();
        test_lz();
        test_back_to_back();
        test_reset_midslot();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
